lane_density_encoder: RTL and testbench

//  Sensor front-end feeding the adaptive traffic controller. Turns raw per-lane vehicle

---
 rtl/lane_density_encoder.sv | 182 ++++++++++++++++++
 tb/tb_lane_density_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lane_density_encoder.sv
// ============================================================================
//  Module   : lane_density_encoder
//  Brief    : Per-lane detector conditioning, saturating queue counters and
//             hysteretic 2-bit density quantisers for four traffic lanes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_density_encoder #(
    parameter int CNT_W = 6,
    parameter int DEB   = 3,
    parameter int TH1   = 4,
    parameter int TH2   = 10,
    parameter int TH3   = 20,
    parameter int HYST  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           arr,
    input  logic [3:0]           dep,
    input  logic                 clr_flags,
    output logic [1:0]           Sa,
    output logic [1:0]           Sb,
    output logic [1:0]           Sc,
    output logic [1:0]           Sd,
    output logic [4*CNT_W-1:0]   cnt,
    output logic [3:0]           ovf,
    output logic [3:0]           udf
);

    localparam int                  c_STAB_W    = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(DEB - 1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]    c_TH1       = CNT_W'(TH1);
    localparam logic [CNT_W-1:0]    c_TH2       = CNT_W'(TH2);
    localparam logic [CNT_W-1:0]    c_TH3       = CNT_W'(TH3);
    localparam logic [CNT_W-1:0]    c_TH1_LO    = CNT_W'(TH1 - HYST);
    localparam logic [CNT_W-1:0]    c_TH2_LO    = CNT_W'(TH2 - HYST);
    localparam logic [CNT_W-1:0]    c_TH3_LO    = CNT_W'(TH3 - HYST);

    // Channels 0..3 are arrival detectors of lanes a..d, 4..7 the departures.
    logic [7:0]      r_sync1;
    logic [7:0]      r_sync2;
    logic [7:0]      w_evt;
    logic [3:0][1:0] w_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {dep, arr};
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < 8; i++) begin : g_chan
            logic [c_STAB_W-1:0] r_stab;
            logic                r_filt;
            logic                r_filt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stab   <= '0;
                    r_filt   <= 1'b0;
                    r_filt_q <= 1'b0;
                end else begin
                    r_filt_q <= r_filt;
                    if (r_sync2[i] != r_filt) begin
                        if (r_stab == c_STAB_LAST) begin
                            r_filt <= ~r_filt;
                            r_stab <= '0;
                        end else begin
                            r_stab <= r_stab + 1'b1;
                        end
                    end else begin
                        r_stab <= '0;
                    end
                end
            end

            assign w_evt[i] = r_filt & ~r_filt_q;
        end
    endgenerate

    generate
        for (genvar l = 0; l < 4; l++) begin : g_lane
            logic [CNT_W-1:0] r_cnt;
            logic [1:0]       r_lvl;
            logic             r_ovf;
            logic             r_udf;
            logic             w_arr_only;
            logic             w_dep_only;
            logic             w_ovf_set;
            logic             w_udf_set;
            logic [CNT_W-1:0] w_up_th;
            logic [CNT_W-1:0] w_dn_th;

            assign w_arr_only = w_evt[l] & ~w_evt[l+4];
            assign w_dep_only = w_evt[l+4] & ~w_evt[l];
            assign w_ovf_set  = w_arr_only & (r_cnt == c_CNT_MAX);
            assign w_udf_set  = w_dep_only & (r_cnt == '0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_arr_only && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_dep_only && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            // A new saturation event outranks a simultaneous clear request.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                    r_udf <= 1'b0;
                end else begin
                    if (w_ovf_set) begin
                        r_ovf <= 1'b1;
                    end else if (clr_flags) begin
                        r_ovf <= 1'b0;
                    end
                    if (w_udf_set) begin
                        r_udf <= 1'b1;
                    end else if (clr_flags) begin
                        r_udf <= 1'b0;
                    end
                end
            end

            always_comb begin
                w_up_th = c_CNT_MAX;
                w_dn_th = '0;
                case (r_lvl)
                    2'd0: begin
                        w_up_th = c_TH1;
                        w_dn_th = '0;
                    end
                    2'd1: begin
                        w_up_th = c_TH2;
                        w_dn_th = c_TH1_LO;
                    end
                    2'd2: begin
                        w_up_th = c_TH3;
                        w_dn_th = c_TH2_LO;
                    end
                    default: begin
                        w_up_th = c_CNT_MAX;
                        w_dn_th = c_TH3_LO;
                    end
                endcase
            end

            // Single step per cycle; the upward test has priority.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lvl <= 2'd0;
                end else if ((r_lvl != 2'd3) && (r_cnt >= w_up_th)) begin
                    r_lvl <= r_lvl + 2'd1;
                end else if ((r_lvl != 2'd0) && (r_cnt < w_dn_th)) begin
                    r_lvl <= r_lvl - 2'd1;
                end
            end

            assign cnt[l*CNT_W +: CNT_W] = r_cnt;
            assign w_lvl[l]              = r_lvl;
            assign ovf[l]                = r_ovf;
            assign udf[l]                = r_udf;
        end
    endgenerate

    assign Sa = w_lvl[0];
    assign Sb = w_lvl[1];
    assign Sc = w_lvl[2];
    assign Sd = w_lvl[3];

endmodule

`default_nettype wire

// File: tb/tb_lane_density_encoder.sv
// ============================================================================
//  Module   : tb_lane_density_encoder
//  Brief    : Directed, table-driven bench for lane_density_encoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lane_density_encoder;

    localparam int CW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      arr;
    logic [3:0]      dep;
    logic            clr_flags;
    logic [1:0]      Sa, Sb, Sc, Sd;
    logic [4*CW-1:0] cnt;
    logic [3:0]      ovf;
    logic [3:0]      udf;
    logic [7:0]      s_bus;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]      a;
        logic [3:0]      d;
        int              hold;
        logic [4*CW-1:0] c;
        logic [7:0]      s;
        logic [3:0]      o;
        logic [3:0]      u;
    } vec_t;

    vec_t tbl[$];

    lane_density_encoder #(
        .CNT_W(CW), .DEB(3), .TH1(4), .TH2(10), .TH3(20), .HYST(2)
    ) dut (
        .clk(clk), .rst(rst), .arr(arr), .dep(dep), .clr_flags(clr_flags),
        .Sa(Sa), .Sb(Sb), .Sc(Sc), .Sd(Sd), .cnt(cnt), .ovf(ovf), .udf(udf)
    );

    assign s_bus = {Sd, Sc, Sb, Sa};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4*CW-1:0] pk(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic logic [7:0] sp(input int a, input int b, input int c, input int d);
        return {2'(d), 2'(c), 2'(b), 2'(a)};
    endfunction

    // Level reached by a count that has been climbing monotonically.
    function automatic int lvl_up(input int c);
        return (c >= 20) ? 3 : (c >= 10) ? 2 : (c >= 4) ? 1 : 0;
    endfunction

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] d, input int hold,
                                input logic [4*CW-1:0] c, input logic [7:0] s,
                                input logic [3:0] o, input logic [3:0] u);
        vec_t v;
        v.a = a; v.d = d; v.hold = hold; v.c = c; v.s = s; v.o = o; v.u = u;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] a, input logic [3:0] d);
        arr = a;
        dep = d;
        repeat (4) tick();
        arr = '0;
        dep = '0;
        repeat (6) tick();
    endtask

    task automatic apply(input vec_t r, input logic [4*CW-1:0] pc, input logic [7:0] ps,
                         input int idx);
        arr = r.a;
        dep = r.d;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == r.hold) begin
                arr = '0;
                dep = '0;
            end
            if (i == 5) chk($sformatf("v%0d cnt_before", idx), 32'(cnt), 32'(pc));
            if (i == 6) begin
                chk($sformatf("v%0d cnt_at_lat", idx), 32'(cnt), 32'(r.c));
                chk($sformatf("v%0d S_before", idx), 32'(s_bus), 32'(ps));
            end
            if (i == 7) chk($sformatf("v%0d S_at_lat", idx), 32'(s_bus), 32'(r.s));
            if (i == 10) begin
                chk($sformatf("v%0d ovf", idx), 32'(ovf), 32'(r.o));
                chk($sformatf("v%0d udf", idx), 32'(udf), 32'(r.u));
            end
        end
    endtask

    initial begin
        logic [4*CW-1:0] pc;
        logic [7:0]      ps;

        rst = 1'b1; arr = 4'hF; dep = '0; clr_flags = 1'b0;

        // Reset with every arrival detector held high.
        tick(); tick();
        chk("rst cnt", 32'(cnt), 32'(0));
        chk("rst S", 32'(s_bus), 32'(0));
        chk("rst ovf", 32'(ovf), 32'(0));
        chk("rst udf", 32'(udf), 32'(0));
        rst = 1'b0;
        repeat (5) tick();
        chk("rel cnt_early", 32'(cnt), 32'(0));
        tick();
        chk("rel cnt_first", 32'(cnt), 32'(pk(1, 1, 1, 1)));
        arr = '0;
        repeat (10) tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst2 cnt", 32'(cnt), 32'(0));

        // Lane a: glitch, boundary pulse, climb through TH1, descend with hysteresis.
        tbl.push_back(mk(4'b0001, 4'b0000, 2, pk(0, 0, 0, 0), sp(0, 0, 0, 0), 4'h0, 4'h0));
        tbl.push_back(mk(4'b0001, 4'b0000, 3, pk(1, 0, 0, 0), sp(0, 0, 0, 0), 4'h0, 4'h0));
        tbl.push_back(mk(4'b0001, 4'b0000, 4, pk(2, 0, 0, 0), sp(0, 0, 0, 0), 4'h0, 4'h0));
        tbl.push_back(mk(4'b0001, 4'b0000, 4, pk(3, 0, 0, 0), sp(0, 0, 0, 0), 4'h0, 4'h0));
        tbl.push_back(mk(4'b0001, 4'b0000, 4, pk(4, 0, 0, 0), sp(1, 0, 0, 0), 4'h0, 4'h0));
        tbl.push_back(mk(4'b0000, 4'b0001, 4, pk(3, 0, 0, 0), sp(1, 0, 0, 0), 4'h0, 4'h0));
        tbl.push_back(mk(4'b0000, 4'b0001, 4, pk(2, 0, 0, 0), sp(1, 0, 0, 0), 4'h0, 4'h0));
        tbl.push_back(mk(4'b0000, 4'b0001, 4, pk(1, 0, 0, 0), sp(0, 0, 0, 0), 4'h0, 4'h0));
        tbl.push_back(mk(4'b0000, 4'b0001, 4, pk(0, 0, 0, 0), sp(0, 0, 0, 0), 4'h0, 4'h0));
        tbl.push_back(mk(4'b0000, 4'b0001, 1, pk(0, 0, 0, 0), sp(0, 0, 0, 0), 4'h0, 4'h0));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(4'b0010, 4'b0000, 4, pk(0, k, 0, 0), sp(0, lvl_up(k), 0, 0),
                             4'h0, 4'h0));
        tbl.push_back(mk(4'b0010, 4'b0010, 4, pk(0, 5, 0, 0), sp(0, 1, 0, 0), 4'h0, 4'h0));
        for (int k = 1; k <= 11; k++)
            tbl.push_back(mk(4'b1001, 4'b0000, 4, pk(k, 5, 0, k),
                             sp(lvl_up(k), 1, 0, lvl_up(k)), 4'h0, 4'h0));
        for (int k = 12; k <= 21; k++)
            tbl.push_back(mk(4'b1000, 4'b0000, 4, pk(11, 5, 0, k),
                             sp(2, 1, 0, lvl_up(k)), 4'h0, 4'h0));

        pc = '0;
        ps = '0;
        for (int n = 0; n < tbl.size(); n++) begin
            apply(tbl[n], pc, ps, n);
            pc = tbl[n].c;
            ps = tbl[n].s;
        end

        // Lane c: saturation, flag clearing, clear/set collision, drain, underflow.
        for (int k = 0; k < 63; k++) pulse(4'b0100, 4'b0000);
        chk("c63 cnt", 32'(cnt), 32'(pk(11, 5, 63, 21)));
        chk("c63 Sc", 32'(Sc), 32'(3));
        chk("c63 ovf", 32'(ovf), 32'(0));
        pulse(4'b0100, 4'b0000);
        chk("c64 cnt", 32'(cnt[2*CW +: CW]), 32'(63));
        chk("c64 ovf", 32'(ovf), 32'(4'b0100));
        clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
        chk("clr ovf", 32'(ovf), 32'(0));

        arr = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 4) arr = '0;
            if (i == 5) clr_flags = 1'b1;
            if (i == 6) clr_flags = 1'b0;
        end
        chk("collide ovf", 32'(ovf), 32'(4'b0100));
        chk("collide cnt", 32'(cnt[2*CW +: CW]), 32'(63));
        clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
        chk("clr2 ovf", 32'(ovf), 32'(0));

        for (int k = 0; k < 5; k++) pulse(4'b0100, 4'b0000);
        chk("c70 cnt", 32'(cnt[2*CW +: CW]), 32'(63));
        chk("c70 ovf", 32'(ovf), 32'(4'b0100));
        clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
        chk("clr3 ovf", 32'(ovf), 32'(0));

        for (int k = 0; k < 45; k++) pulse(4'b0000, 4'b0100);
        chk("c18 cnt", 32'(cnt[2*CW +: CW]), 32'(18));
        chk("c18 Sc", 32'(Sc), 32'(3));
        pulse(4'b0000, 4'b0100);
        chk("c17 cnt", 32'(cnt[2*CW +: CW]), 32'(17));
        chk("c17 Sc", 32'(Sc), 32'(2));
        for (int k = 0; k < 17; k++) pulse(4'b0000, 4'b0100);
        chk("c0 cnt", 32'(cnt[2*CW +: CW]), 32'(0));
        chk("c0 Sc", 32'(Sc), 32'(0));
        chk("c0 udf", 32'(udf), 32'(0));
        pulse(4'b0000, 4'b0100);
        chk("udf cnt", 32'(cnt), 32'(pk(11, 5, 0, 21)));
        chk("udf flag", 32'(udf), 32'(4'b0100));
        chk("final S", 32'(s_bus), 32'(sp(2, 1, 0, 3)));
        chk("final ovf", 32'(ovf), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
